// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential ROM fetch with a small {pc, instr} FIFO toward FD.
// Optional IFQ_BYPASS_EN forwards a returning ROM word straight to the outputs when the queue is empty.
module instr_prefetch_queue #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INSTR_W = 10,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   rom_req,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [INSTR_W-1:0]     rom_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [INSTR_W-1:0]     out_instr,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   input  logic                   halt_in,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               pend_q, pend_d;
   logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
   logic               halted_q, halted_d;
   logic               started_q, started_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];

   logic redir;
   logic credit_ok;
   logic issue;
   logic resp_ok;
   logic head_valid;
   logic push;
   logic pop;
   logic bypass;

   // Handshake decode; a redirect coinciding with halt_in is dropped so halt wins.
   always_comb begin
      redir      = redirect_valid && !halted_q && !halt_in;
      credit_ok  = (occ_q + OCC_W'(pend_q)) < OCC_W'(DEPTH);
      issue      = started_q && !halted_q && !redirect_valid && credit_ok;
      resp_ok    = pend_q && !halted_q && !redir;
      head_valid = (occ_q != '0) && !halted_q;
      pop        = head_valid && out_ready && !redir;
`ifdef IFQ_BYPASS_EN
      bypass     = resp_ok && (occ_q == '0);
      push       = resp_ok && !(bypass && out_ready);
`else
      bypass     = 1'b0;
      push       = resp_ok;
`endif
   end

   assign rom_req   = issue;
   assign rom_addr  = fetch_pc_q;
   assign occupancy = occ_q;

`ifdef IFQ_BYPASS_EN
   assign out_valid = head_valid || bypass;
   assign out_pc    = bypass ? pend_pc_q : pc_mem_q[rd_ptr_q];
   assign out_instr = bypass ? rom_rdata : instr_mem_q[rd_ptr_q];
`else
   assign out_valid = head_valid && !bypass;
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];
`endif

   // Next-state for fetch pointer, pending response tracker and queue pointers.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_d     = issue;
      pend_pc_d  = pend_pc_q;
      halted_d   = halted_q | halt_in;
      started_d  = 1'b1;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;

      if (issue) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         pend_pc_d  = fetch_pc_q;
      end

      if (redir) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= '0;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         halted_q   <= 1'b0;
         started_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         halted_q   <= halted_d;
         started_q  <= started_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

   // Entry storage is cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= pend_pc_q;
         instr_mem_q[wr_ptr_q] <= rom_rdata;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue with a 1-cycle ROM model (ROM[i] = i ^ 0x155).
module tb_instr_prefetch_queue;

   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned INSTR_W = 10;
   localparam int unsigned DEPTH   = 4;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic               clk;
   logic               rst_n;
   logic               rom_req;
   logic [ADDR_W-1:0]  rom_addr;
   logic [INSTR_W-1:0] rom_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_W-1:0]  out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               halt_in;
   logic [$clog2(DEPTH):0] occupancy;

   int n_checks = 0;
   int n_errors = 0;
   logic [ADDR_W-1:0] exp_pc;
   int cyc;

   instr_prefetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_req        (rom_req),
      .rom_addr       (rom_addr),
      .rom_rdata      (rom_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_in        (halt_in),
      .occupancy      (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [INSTR_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
      return a ^ 10'h155;
   endfunction

   always @(posedge clk) begin
      if (rom_req) rom_rdata <= rom_val(rom_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rom_req"},   32'(rom_req),   32'd0);
      check({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_pc"},    32'(out_pc),    32'd0);
      check({tag, "_out_instr"}, 32'(out_instr), 32'd0);
      check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
   endtask

   // Ends on the negedge of the cycle where the awaited signal is high (or the budget ran out).
   task automatic wait_for(input string tag, input bit want_valid, input int limit, output int n);
      logic sig;
      n = 0;
      @(negedge clk);
      sig = want_valid ? out_valid : rom_req;
      while (sig !== 1'b1 && n < limit) begin
         tick();
         n++;
         @(negedge clk);
         sig = want_valid ? out_valid : rom_req;
      end
      check(tag, 32'(sig), 32'd1);
   endtask

   task automatic stream(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         out_ready = rdy;
         @(negedge clk);
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_pc",    32'(out_pc),    32'(exp_pc));
         check("stream_instr", 32'(out_instr), 32'(rom_val(exp_pc)));
         if (rdy) exp_pc++;
         tick();
      end
   endtask

   task automatic redirect_to(input logic [ADDR_W-1:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      out_ready      = 1'b1;
      @(negedge clk);
      check("redir_no_req", 32'(rom_req), 32'd0);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      @(negedge clk);
      check("redir_flushed", 32'(out_valid), 32'd0);
      check("redir_req",     32'(rom_req),   32'd1);
      check("redir_addr",    32'(rom_addr),  32'(pc));
      tick();
      wait_for("redir_wait_valid", 1'b1, 20, cyc);
      check("redir_latency", 32'(cyc), 32'(LAT - 1));
      check("redir_first_pc", 32'(out_pc), 32'(pc));
      tick();
      exp_pc = pc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt_in        = 1'b0;
      #12;
      check_reset("rst");
      tick();
      rst_n = 1'b1;

      // Fill and steady streaming
      wait_for("t1_wait_req", 1'b0, 20, cyc);
      check("t1_addr0", 32'(rom_addr), 32'd0);
      tick();
      wait_for("t1_wait_valid", 1'b1, 20, cyc);
      check("t1_latency", 32'(cyc), 32'(LAT - 1));
      check("t1_pc0", 32'(out_pc), 32'd0);
      check("t1_instr0", 32'(out_instr), 32'h155);
      tick();
      exp_pc = '0;
      stream(8, 1'b1);

      // Backpressure saturation and contiguous release
      stream(10, 1'b0);
      @(negedge clk);
      check("t2_occ_full", 32'(occupancy), 32'(DEPTH));
      check("t2_req_stop", 32'(rom_req), 32'd0);
      tick();
      stream(12, 1'b1);

      // Redirect with a response in flight, then wrap-around redirect
      stream(2, 1'b0);
      redirect_to(10'h02A);
      stream(3, 1'b1);
      redirect_to(10'h3FF);
      stream(3, 1'b1);

      // Halt freezes everything; a redirect while halted is ignored
      redirect_to(10'h005);
      halt_in = 1'b1;
      stream(1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         redirect_valid = (i == 8);
         redirect_pc    = 10'h100;
         out_ready      = 1'b1;
         @(negedge clk);
         check("t5_halt_req",   32'(rom_req),   32'd0);
         check("t5_halt_valid", 32'(out_valid), 32'd0);
         tick();
      end
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      rst_n          = 1'b0;
      halt_in        = 1'b0;
      #1;
      check_reset("t5_rst");
      tick();
      rst_n = 1'b1;
      wait_for("t5_wait_req", 1'b0, 20, cyc);
      check("t5_restart_addr", 32'(rom_addr), 32'd0);
      tick();
      wait_for("t5_wait_valid", 1'b1, 20, cyc);
      check("t5_restart_pc", 32'(out_pc), 32'd0);
      tick();
      exp_pc = '0;

      // Asynchronous reset between edges, then simultaneous halt and redirect
      stream(5, 1'b1);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("t6_async");
      tick();
      rst_n = 1'b1;
      wait_for("t6_wait_req", 1'b0, 20, cyc);
      check("t6_addr0", 32'(rom_addr), 32'd0);
      tick();
      halt_in        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 10'h155;
      @(negedge clk);
      check("t6_both_no_req", 32'(rom_req), 32'd0);
      check("t6_both_addr",   32'(rom_addr), 32'd1);
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_pc_held",  32'(rom_addr),  32'd1);
         check("t6_no_req",   32'(rom_req),   32'd0);
         check("t6_no_valid", 32'(out_valid), 32'd0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
